// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_pkg                                                    |
// | Description : Shared types and constants for multicycle_controller:      |
// |               FSM state encoding, opcode / ALU function codes, PSW flag  |
// |               bit positions and the decoded instruction-class record.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } ctrl_state_t;

    localparam logic [4:0] c_OP_ALU   = 5'b00000;
    localparam logic [4:0] c_OP_ADDI  = 5'b00001;
    localparam logic [4:0] c_OP_SUBI  = 5'b00010;
    localparam logic [4:0] c_OP_MOV   = 5'b00011;
    localparam logic [4:0] c_OP_LLI   = 5'b00100;
    localparam logic [4:0] c_OP_LHI   = 5'b00101;
    localparam logic [4:0] c_OP_LDRRI = 5'b00110;
    localparam logic [4:0] c_OP_LDRRR = 5'b00111;
    localparam logic [4:0] c_OP_STRRI = 5'b01000;
    localparam logic [4:0] c_OP_STRRR = 5'b01001;
    localparam logic [4:0] c_OP_BCC   = 5'b01010;
    localparam logic [4:0] c_OP_BCS   = 5'b01011;
    localparam logic [4:0] c_OP_BNE   = 5'b01100;
    localparam logic [4:0] c_OP_BEQ   = 5'b01101;
    localparam logic [4:0] c_OP_BAL   = 5'b01110;
    localparam logic [4:0] c_OP_OUTR  = 5'b01111;
    localparam logic [4:0] c_OP_HLT   = 5'b11111;

    localparam logic [1:0] c_FN_ADD = 2'b00;
    localparam logic [1:0] c_FN_ADC = 2'b01;
    localparam logic [1:0] c_FN_SUB = 2'b10;
    localparam logic [1:0] c_FN_SBB = 2'b11;

    localparam int c_PSW_N = 2;
    localparam int c_PSW_Z = 1;
    localparam int c_PSW_C = 0;

    // Class flags (alu..undef) are one-hot; the trailing qualifiers refine
    // the class so the FSM never has to look at the raw opcode.
    typedef struct packed {
        logic alu;
        logic imm;
        logic mov;
        logic li;
        logic load;
        logic store;
        logic branch;
        logic outr;
        logic halt;
        logic undef;
        logic lhi;    // LI class: high-half variant
        logic ri;     // load/store: register+immediate addressing
        logic carry;  // arithmetic uses carry/borrow in
        logic sub;    // arithmetic subtracts
        logic take;   // branch condition met by current PSW
    } ctrl_class_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_decode                                                 |
// | Description : Combinational instruction classifier. Maps opcode and     |
// |               ALU function onto one-hot class flags plus qualifiers.    |
// | Ports       : opcode[4:0], ALUopcode[1:0], PSW_NZC[2:0] in;             |
// |               o_cls (ctrl_class_t) out                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [1:0]  ALUopcode,
    input  logic [2:0]  PSW_NZC,
    output ctrl_class_t o_cls
);

    always_comb begin
        o_cls = '0;
        case (opcode)
            c_OP_ALU: begin
                o_cls.alu   = 1'b1;
                o_cls.carry = (ALUopcode == c_FN_ADC) || (ALUopcode == c_FN_SBB);
                o_cls.sub   = (ALUopcode == c_FN_SUB) || (ALUopcode == c_FN_SBB);
            end
            c_OP_ADDI:  o_cls.imm = 1'b1;
            c_OP_SUBI: begin
                o_cls.imm = 1'b1;
                o_cls.sub = 1'b1;
            end
            c_OP_MOV:   o_cls.mov = 1'b1;
            c_OP_LLI:   o_cls.li  = 1'b1;
            c_OP_LHI: begin
                o_cls.li  = 1'b1;
                o_cls.lhi = 1'b1;
            end
            c_OP_LDRRI: begin
                o_cls.load = 1'b1;
                o_cls.ri   = 1'b1;
            end
            c_OP_LDRRR: o_cls.load = 1'b1;
            c_OP_STRRI: begin
                o_cls.store = 1'b1;
                o_cls.ri    = 1'b1;
            end
            c_OP_STRRR: o_cls.store = 1'b1;
            c_OP_BCC: begin
                o_cls.branch = 1'b1;
                o_cls.take   = ~PSW_NZC[c_PSW_C];
            end
            c_OP_BCS: begin
                o_cls.branch = 1'b1;
                o_cls.take   = PSW_NZC[c_PSW_C];
            end
            c_OP_BNE: begin
                o_cls.branch = 1'b1;
                o_cls.take   = ~PSW_NZC[c_PSW_Z];
            end
            c_OP_BEQ: begin
                o_cls.branch = 1'b1;
                o_cls.take   = PSW_NZC[c_PSW_Z];
            end
            // BAL is steered by the PC path, not by the Branch strobe
            c_OP_BAL:   o_cls.branch = 1'b1;
            c_OP_OUTR:  o_cls.outr   = 1'b1;
            c_OP_HLT:   o_cls.halt   = 1'b1;
            default:    o_cls.undef  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                       |
// | Description : Multicycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/MEM/    |
// |               WB/HALT). Control strobes decode combinationally from the |
// |               state and the decoded instruction class.                  |
// | Ports       : clk, Rst, Start, opcode[4:0], ALUopcode[1:0], PSW_NZC[2:0]|
// |               in; register/memory enables, datapath selects, Jump[1:0], |
// |               done, illegal out                                         |
// | Config      : CTRL_ILLEGAL_TRAP_EN - undefined opcodes halt and raise  |
// |               sticky illegal; otherwise they behave like OutR.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [4:0] opcode,
    input  logic [1:0] ALUopcode,
    input  logic [2:0] PSW_NZC,
    output logic       Buff_MEMIns,
    output logic       Buff_PC,
    output logic       Buff_PSW,
    output logic       WE_RF,
    output logic       WE_MEM,
    output logic       MEMresource,
    output logic       ALUorNot,
    output logic       LIorMOV,
    output logic       WBresource,
    output logic       RBresource,
    output logic       oprandB,
    output logic       LI,
    output logic       PCplus1orWB,
    output logic       Flag,
    output logic       ALUop,
    output logic       Branch,
    output logic [1:0] Jump,
    output logic       done,
    output logic       illegal
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    ctrl_class_t w_cls;

    ctrl_decode u_decode (
        .opcode    (opcode),
        .ALUopcode (ALUopcode),
        .PSW_NZC   (PSW_NZC),
        .o_cls     (w_cls)
    );

    assign Jump = 2'b00;

    always_ff @(posedge clk) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk) begin
        if (Rst)
            r_illegal <= 1'b0;
        else if (r_state == S_DECODE && w_cls.undef)
            r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        Buff_MEMIns = 1'b0;
        Buff_PC     = 1'b0;
        Buff_PSW    = 1'b0;
        WE_RF       = 1'b0;
        WE_MEM      = 1'b0;
        MEMresource = 1'b0;
        ALUorNot    = 1'b0;
        LIorMOV     = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        oprandB     = 1'b0;
        LI          = 1'b0;
        PCplus1orWB = 1'b0;
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Branch      = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Start) w_state_nxt = S_FETCH;
            end
            // opcode is not yet valid here, so nothing may depend on w_cls
            S_FETCH: begin
                Buff_MEMIns = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_cls.branch || w_cls.outr || w_cls.halt) begin
                    Buff_PC     = 1'b1;
                    Branch      = w_cls.take;
                    w_state_nxt = w_cls.halt ? S_HALT : S_FETCH;
                end else if (w_cls.undef) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_state_nxt = S_HALT;
`else
                    Buff_PC     = 1'b1;
                    w_state_nxt = S_FETCH;
`endif
                end else begin
                    oprandB     = w_cls.imm || ((w_cls.load || w_cls.store) && w_cls.ri);
                    RBresource  = w_cls.lhi;
                    LI          = w_cls.lhi;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cls.alu || w_cls.imm) begin
                    Buff_PSW = 1'b1;
                    Flag     = w_cls.carry;
                    ALUop    = w_cls.sub;
                end
                RBresource  = w_cls.store;
                w_state_nxt = S_MEM;
            end
            S_MEM: begin
                ALUorNot    = w_cls.li || w_cls.mov;
                LIorMOV     = w_cls.mov;
                MEMresource = w_cls.load || w_cls.store;
                if (w_cls.store) begin
                    WE_MEM      = 1'b1;
                    Buff_PC     = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                WE_RF       = 1'b1;
                PCplus1orWB = 1'b1;
                Buff_PC     = 1'b1;
                WBresource  = w_cls.load;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
